// File: rtl/mux_select_slice.sv
// Registered 4:1 + independent 2:1 mux slice with active-low enables and true/complement outputs.
// Latency: one cycle, new inputs every cycle; there is no handshake and no backpressure.
module mux_select_slice #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    input  logic [WIDTH-1:0] i_d3,
    input  logic             i_s0,
    input  logic             i_s1,
    input  logic             i_enb,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_a1,
    input  logic             i_s,
    input  logic             i_enb2,
    output logic [WIDTH-1:0] o_y4,
    output logic [WIDTH-1:0] o_w4,
    output logic [WIDTH-1:0] o_y2,
    output logic [WIDTH-1:0] o_w2,
    output logic             o_sb
);

    logic [WIDTH-1:0] w_y4_nxt;
    logic [WIDTH-1:0] w_y2_nxt;

    logic [WIDTH-1:0] r_y4;
    logic [WIDTH-1:0] r_w4;
    logic [WIDTH-1:0] r_y2;
    logic [WIDTH-1:0] r_w2;
    logic             r_sb;

    // Enable is resolved before the select decode; an unknown select yields X in simulation.
    always_comb begin
        w_y4_nxt = '0;
        if (!i_enb) begin
            case ({i_s1, i_s0})
                2'b00:   w_y4_nxt = i_d0;
                2'b01:   w_y4_nxt = i_d1;
                2'b10:   w_y4_nxt = i_d2;
                2'b11:   w_y4_nxt = i_d3;
                default: w_y4_nxt = 'x;
            endcase
        end
    end

    always_comb begin
        w_y2_nxt = '0;
        if (!i_enb2) begin
            case (i_s)
                1'b0:    w_y2_nxt = i_a0;
                1'b1:    w_y2_nxt = i_a1;
                default: w_y2_nxt = 'x;
            endcase
        end
    end

    // Complements load from the same next value as the true outputs so a pair can never disagree.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_y4 <= '0;
            r_w4 <= '1;
            r_y2 <= '0;
            r_w2 <= '1;
            r_sb <= 1'b1;
        end else begin
            r_y4 <= w_y4_nxt;
            r_w4 <= ~w_y4_nxt;
            r_y2 <= w_y2_nxt;
            r_w2 <= ~w_y2_nxt;
            r_sb <= ~i_s;
        end
    end

    assign o_y4 = r_y4;
    assign o_w4 = r_w4;
    assign o_y2 = r_y2;
    assign o_w2 = r_w2;
    assign o_sb = r_sb;

endmodule

// File: tb/tb_mux_select_slice.sv
// Bench for mux_select_slice: 8-bit and 1-bit slices share stimulus, plus a three-slice 8:1 cascade.
module tb_mux_select_slice;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d0, d1, d2, d3, a0, a1;
    logic       s0, s1, enb, s, enb2;

    logic [7:0] y4, w4, y2, w2;
    logic       sb;
    logic       y4_1, w4_1, y2_1, w2_1, sb_1;

    logic [7:0] cd;
    logic [2:0] csel;
    logic       cenb;
    logic       c0_y4, c0_w4, c0_y2, c0_w2, c0_sb;
    logic       c1_y4, c1_w4, c1_y2, c1_w2, c1_sb;
    logic       c2_y4, c2_w4, c2_y2, c2_w2, c2_sb;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_y4, m_y2;
    logic       m_sb;
    logic       m_vld = 1'b0;

    always #5 clk = ~clk;

    mux_select_slice #(.WIDTH(8)) u_w8 (
        .i_clk(clk), .i_rst(rst), .i_d0(d0), .i_d1(d1), .i_d2(d2), .i_d3(d3),
        .i_s0(s0), .i_s1(s1), .i_enb(enb), .i_a0(a0), .i_a1(a1), .i_s(s), .i_enb2(enb2),
        .o_y4(y4), .o_w4(w4), .o_y2(y2), .o_w2(w2), .o_sb(sb)
    );

    mux_select_slice #(.WIDTH(1)) u_w1 (
        .i_clk(clk), .i_rst(rst), .i_d0(d0[0]), .i_d1(d1[0]), .i_d2(d2[0]), .i_d3(d3[0]),
        .i_s0(s0), .i_s1(s1), .i_enb(enb), .i_a0(a0[0]), .i_a1(a1[0]), .i_s(s), .i_enb2(enb2),
        .o_y4(y4_1), .o_w4(w4_1), .o_y2(y2_1), .o_w2(w2_1), .o_sb(sb_1)
    );

    mux_select_slice #(.WIDTH(1)) u_c0 (
        .i_clk(clk), .i_rst(rst), .i_d0(cd[0]), .i_d1(cd[1]), .i_d2(cd[2]), .i_d3(cd[3]),
        .i_s0(csel[0]), .i_s1(csel[1]), .i_enb(cenb), .i_a0(1'b0), .i_a1(1'b0), .i_s(1'b0), .i_enb2(1'b1),
        .o_y4(c0_y4), .o_w4(c0_w4), .o_y2(c0_y2), .o_w2(c0_w2), .o_sb(c0_sb)
    );

    mux_select_slice #(.WIDTH(1)) u_c1 (
        .i_clk(clk), .i_rst(rst), .i_d0(cd[4]), .i_d1(cd[5]), .i_d2(cd[6]), .i_d3(cd[7]),
        .i_s0(csel[0]), .i_s1(csel[1]), .i_enb(cenb), .i_a0(1'b0), .i_a1(1'b0), .i_s(1'b0), .i_enb2(1'b1),
        .o_y4(c1_y4), .o_w4(c1_w4), .o_y2(c1_y2), .o_w2(c1_w2), .o_sb(c1_sb)
    );

    mux_select_slice #(.WIDTH(1)) u_c2 (
        .i_clk(clk), .i_rst(rst), .i_d0(1'b0), .i_d1(1'b0), .i_d2(1'b0), .i_d3(1'b0),
        .i_s0(1'b0), .i_s1(1'b0), .i_enb(1'b1), .i_a0(c0_y4), .i_a1(c1_y4), .i_s(csel[2]), .i_enb2(cenb),
        .o_y4(c2_y4), .o_w4(c2_w4), .o_y2(c2_y2), .o_w2(c2_w2), .o_sb(c2_sb)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick an element of the data array by index, or zero when disabled.
    always @(posedge clk) begin
        logic [7:0] dv [4];
        logic [7:0] av [2];
        dv = '{d0, d1, d2, d3};
        av = '{a0, a1};
        if (rst) begin
            m_y4 = 8'h00;
            m_y2 = 8'h00;
            m_sb = 1'b1;
        end else begin
            m_y4 = enb  ? 8'h00 : dv[{s1, s0}];
            m_y2 = enb2 ? 8'h00 : av[s];
            m_sb = !s;
        end
        m_vld = 1'b1;
    end

    always @(negedge clk) begin
        if (m_vld) begin
            chk("m_y4",   y4,   m_y4);
            chk("m_w4",   w4,   ~m_y4);
            chk("m_y2",   y2,   m_y2);
            chk("m_w2",   w2,   ~m_y2);
            chk("m_sb",   {7'd0, sb},   {7'd0, m_sb});
            chk("m_y4_1", {7'd0, y4_1}, {7'd0, m_y4[0]});
            chk("m_w4_1", {7'd0, w4_1}, {7'd0, ~m_y4[0]});
            chk("m_y2_1", {7'd0, y2_1}, {7'd0, m_y2[0]});
            chk("m_w2_1", {7'd0, w2_1}, {7'd0, ~m_y2[0]});
            chk("m_sb_1", {7'd0, sb_1}, {7'd0, m_sb});
        end
    end

    initial begin
        logic [1:0] sel4 [4];
        logic [3:0] exp4;
        logic       svec [3];
        logic [2:0] exp2;
        sel4 = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp4 = 4'b0100;
        svec = '{1'b0, 1'b1, 1'b0};
        exp2 = 3'b010;

        rst = 1'b1; d0 = 8'h01; d1 = 8'h01; d2 = 8'h01; d3 = 8'h01;
        s0 = 1'b0; s1 = 1'b0; enb = 1'b0; s = 1'b0; enb2 = 1'b0;
        a0 = 8'h01; a1 = 8'h01;
        cd = 8'h00; csel = 3'd0; cenb = 1'b0;
        @(negedge clk);
        chk("rst_y4", y4, 8'h00);
        chk("rst_w4", w4, 8'hFF);
        chk("rst_y2", y2, 8'h00);
        chk("rst_w2", w2, 8'hFF);
        chk("rst_sb", {7'd0, sb}, 8'h01);

        rst = 1'b0; s1 = 1'b0; s0 = 1'b1;
        @(negedge clk);
        chk("rel_y4_1", {7'd0, y4_1}, 8'h01);
        chk("rel_w4_1", {7'd0, w4_1}, 8'h00);

        d0 = 8'h00; d1 = 8'h00; d2 = 8'h01; d3 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            {s1, s0} = sel4[i];
            @(negedge clk);
            chk("sweep4", {7'd0, y4_1}, {7'd0, exp4[i]});
        end

        a0 = 8'h00; a1 = 8'h01; enb2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s = svec[i];
            @(negedge clk);
            chk("sweep2_y", {7'd0, y2_1}, {7'd0, exp2[i]});
            chk("sweep2_sb", {7'd0, sb_1}, {7'd0, ~exp2[i]});
        end

        d0 = 8'h01; d1 = 8'h01; d2 = 8'h01; d3 = 8'h01; a0 = 8'h01; a1 = 8'h01;
        enb = 1'b1; enb2 = 1'b1;
        @(negedge clk);
        chk("gate_y4", {7'd0, y4_1}, 8'h00);
        chk("gate_y2", {7'd0, y2_1}, 8'h00);
        chk("gate_w4", {7'd0, w4_1}, 8'h01);
        chk("gate_w2", {7'd0, w2_1}, 8'h01);
        enb = 1'b0;
        @(negedge clk);
        chk("ungate_y4", {7'd0, y4_1}, 8'h01);
        chk("ungate_y2", {7'd0, y2_1}, 8'h00);

        d0 = 8'h0F; d1 = 8'hF0; d2 = 8'hAA; d3 = 8'h55; {s1, s0} = 2'b11;
        @(negedge clk);
        chk("wide_y4", y4, 8'h55);
        chk("wide_w4", w4, 8'hAA);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_y4", y4, 8'h00);
        chk("midrst_w4", w4, 8'hFF);
        rst = 1'b0;

        cd = 8'b0010_0000;
        for (int i = 0; i < 8; i++) begin
            csel = 3'(i);
            repeat (2) @(negedge clk);
            chk("cascade", {7'd0, c2_y2}, (i == 5) ? 8'h01 : 8'h00);
        end

        for (int i = 0; i < 24; i++) begin
            d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
            a0 = 8'($urandom); a1 = 8'($urandom);
            {s1, s0} = 2'($urandom); s = 1'($urandom);
            enb = ($urandom_range(0, 3) == 0); enb2 = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 9) == 0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
